// File: rtl/branch_resolve_unit.sv
// EX-stage control-flow resolver: computes the real next PC, redirects IF on a
// predictor miss, and feeds one registered update per resolved instruction back.
module branch_resolve_unit #(
  parameter int unsigned SQUASH_CYCLES = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_pred_next_pc,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_bcond,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_rs1_data,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             upd_valid,
  output logic             upd_is_branch,
  output logic             upd_is_jal,
  output logic             upd_is_jalr,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_actual_target,
  output logic             upd_actual_taken,
  output logic             upd_prediction_correct,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_SQUASH = 2'd2;
  localparam logic [2:0] SQ_INIT  = 3'(SQUASH_CYCLES);
  localparam bit         SQ_EN    = (SQUASH_CYCLES != 0);

  logic [1:0]  state;
  logic [2:0]  cnt;
  logic        held_miss;

  logic        cfi, taken, correct, resolve, miss;
  logic [31:0] target, seq_pc, actual_next;

  always_comb begin
    cfi         = ex_is_branch | ex_is_jal | ex_is_jalr;
    target      = ex_is_jalr ? ((ex_rs1_data + ex_imm) & ~32'h1) : (ex_pc + ex_imm);
    taken       = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
    seq_pc      = ex_pc + 32'd4;
    actual_next = taken ? target : seq_pc;
    correct     = (actual_next == ex_pred_next_pc);
    // Only IDLE resolves; HOLD already did and SQUASH drains the wrong path.
    resolve     = reset && (state == S_IDLE) && ex_valid && cfi;
    miss        = resolve && !correct;
  end

  assign redirect_valid = miss;
  assign redirect_pc    = miss ? actual_next : 32'h0;
  assign flush_if_id    = miss;
  assign flush_id_ex    = miss;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      held_miss <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (resolve) begin
            if (ex_stall) begin
              state     <= S_HOLD;
              held_miss <= !correct;
            end else if (!correct && SQ_EN) begin
              state <= S_SQUASH;
              cnt   <= SQ_INIT;
            end
          end
        end
        S_HOLD: begin
          if (!ex_stall) begin
            if (held_miss && SQ_EN) begin
              state <= S_SQUASH;
              cnt   <= SQ_INIT;
            end else begin
              state <= S_IDLE;
            end
            held_miss <= 1'b0;
          end
        end
        S_SQUASH: begin
          if (cnt <= 3'd1) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      upd_valid              <= 1'b0;
      upd_is_branch          <= 1'b0;
      upd_is_jal             <= 1'b0;
      upd_is_jalr            <= 1'b0;
      upd_pc                 <= 32'h0;
      upd_actual_target      <= 32'h0;
      upd_actual_taken       <= 1'b0;
      upd_prediction_correct <= 1'b0;
    end else begin
      upd_valid <= resolve;
      if (resolve) begin
        upd_is_branch          <= ex_is_branch;
        upd_is_jal             <= ex_is_jal;
        upd_is_jalr            <= ex_is_jalr;
        upd_pc                 <= ex_pc;
        upd_actual_target      <= target;
        upd_actual_taken       <= taken;
        upd_prediction_correct <= correct;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (resolve && (branch_count != '1))
        branch_count <= branch_count + 1'b1;
      if (miss && (mispredict_count != '1))
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect checked in-cycle, predictor
// updates checked through a scoreboard queue one cycle later.
module tb_branch_resolve_unit;

  localparam int CW  = 4;
  localparam int MAX = 15;

  typedef struct packed {
    logic        is_br, is_jal, is_jalr;
    logic [31:0] pc, target;
    logic        taken, correct;
  } upd_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ex_valid, ex_stall, ex_is_branch, ex_is_jal, ex_is_jalr, ex_bcond;
  logic [31:0]   ex_pc, ex_pred_next_pc, ex_imm, ex_rs1_data;
  logic          redirect_valid, flush_if_id, flush_id_ex;
  logic [31:0]   redirect_pc;
  logic          upd_valid, upd_is_branch, upd_is_jal, upd_is_jalr;
  logic [31:0]   upd_pc, upd_actual_target;
  logic          upd_actual_taken, upd_prediction_correct;
  logic [CW-1:0] branch_count, mispredict_count;

  upd_t q[$];
  int   total = 0, bad = 0;
  int   eb = 0, em = 0;

  branch_resolve_unit #(.SQUASH_CYCLES(1), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .ex_pred_next_pc(ex_pred_next_pc),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_bcond(ex_bcond), .ex_imm(ex_imm), .ex_rs1_data(ex_rs1_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .upd_valid(upd_valid), .upd_is_branch(upd_is_branch), .upd_is_jal(upd_is_jal),
    .upd_is_jalr(upd_is_jalr), .upd_pc(upd_pc), .upd_actual_target(upd_actual_target),
    .upd_actual_taken(upd_actual_taken), .upd_prediction_correct(upd_prediction_correct),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic st, input logic br, input logic jal,
                       input logic jalr, input logic bc, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] pred);
    ex_valid = v; ex_stall = st; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_bcond = bc; ex_pc = pc; ex_imm = imm; ex_rs1_data = rs1; ex_pred_next_pc = pred;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // One clock with the current inputs; exp_res says whether this cycle resolves.
  task automatic cyc(input bit exp_res);
    logic [31:0] tgt, nxt;
    logic        tk, ok, rv;
    upd_t        e, got;
    #1;
    tgt = ex_is_jalr ? ((ex_rs1_data + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    tk  = ex_is_jal | ex_is_jalr | (ex_is_branch & ex_bcond);
    nxt = tk ? tgt : ex_pc + 32'd4;
    ok  = (nxt == ex_pred_next_pc);
    rv  = exp_res && !ok;
    chk("redirect_valid", {31'b0, redirect_valid}, {31'b0, rv});
    chk("redirect_pc", redirect_pc, rv ? nxt : 32'h0);
    chk("flush_if_id", {31'b0, flush_if_id}, {31'b0, rv});
    chk("flush_id_ex", {31'b0, flush_id_ex}, {31'b0, rv});
    if (exp_res) begin
      e = '{is_br: ex_is_branch, is_jal: ex_is_jal, is_jalr: ex_is_jalr,
            pc: ex_pc, target: tgt, taken: tk, correct: ok};
      q.push_back(e);
      if (eb < MAX) eb++;
      if (!ok && em < MAX) em++;
    end
    @(posedge clk); #1;
    chk("upd_valid", {31'b0, upd_valid}, {31'b0, q.size() != 0});
    if (q.size() != 0 && upd_valid === 1'b1) begin
      e   = q.pop_front();
      got = '{is_br: upd_is_branch, is_jal: upd_is_jal, is_jalr: upd_is_jalr,
              pc: upd_pc, target: upd_actual_target, taken: upd_actual_taken,
              correct: upd_prediction_correct};
      chk("upd_types", {29'b0, got.is_br, got.is_jal, got.is_jalr},
          {29'b0, e.is_br, e.is_jal, e.is_jalr});
      chk("upd_pc", got.pc, e.pc);
      chk("upd_target", got.target, e.target);
      chk("upd_taken", {31'b0, got.taken}, {31'b0, e.taken});
      chk("upd_correct", {31'b0, got.correct}, {31'b0, e.correct});
    end else if (q.size() != 0) begin
      void'(q.pop_front());
    end
    chk("branch_count", {28'b0, branch_count}, eb);
    chk("mispredict_count", {28'b0, mispredict_count}, em);
  endtask

  // Reset cycle with a mispredicting branch on the inputs to prove outputs are forced low.
  task automatic cyc_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h40, 32'h0, 32'h504);
    #1;
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_flush", {30'b0, flush_if_id, flush_id_ex}, 32'h0);
    @(posedge clk); #1;
    q.delete();
    eb = 0; em = 0;
    chk("rst_upd_valid", {31'b0, upd_valid}, 32'h0);
    chk("rst_upd_bits", {26'b0, upd_is_branch, upd_is_jal, upd_is_jalr,
        upd_actual_taken, upd_prediction_correct, 1'b0}, 32'h0);
    chk("rst_upd_pc", upd_pc, 32'h0);
    chk("rst_upd_target", upd_actual_target, 32'h0);
    chk("rst_counts", {24'b0, branch_count, mispredict_count}, 32'h0);
    reset = 1'b1;
    idle_in();
  endtask

  initial begin
    reset = 1'b0;
    idle_in();
    @(posedge clk); #1;
    cyc_reset();
    cyc_reset();

    // Correct not-taken branch; target still reported.
    drive(1, 0, 1, 0, 0, 0, 32'h100, 32'h20, 32'h0, 32'h104); cyc(1);
    // Non-cfi valid instruction is ignored.
    drive(1, 0, 0, 0, 0, 0, 32'h104, 32'h8, 32'h0, 32'h999); cyc(0);
    // Mispredicted taken branch, then one squashed cfi.
    drive(1, 0, 1, 0, 0, 1, 32'h200, 32'h40, 32'h0, 32'h204); cyc(1);
    drive(1, 0, 1, 0, 0, 1, 32'h204, 32'h40, 32'h0, 32'h208); cyc(0);
    // JALR with odd sum, low bit cleared.
    drive(1, 0, 0, 0, 1, 0, 32'h600, 32'h4, 32'h1003, 32'h1007); cyc(1);
    idle_in(); cyc(0);
    // Correct JAL.
    drive(1, 0, 0, 1, 0, 0, 32'h300, 32'h80, 32'h0, 32'h380); cyc(1);
    // Stalled mispredict: one redirect, one update, then squash.
    drive(1, 1, 1, 0, 0, 1, 32'h400, 32'h10, 32'h0, 32'h404); cyc(1);
    drive(1, 1, 1, 0, 0, 1, 32'h400, 32'h10, 32'h0, 32'h404); cyc(0);
    drive(1, 0, 1, 0, 0, 1, 32'h400, 32'h10, 32'h0, 32'h404); cyc(0);
    drive(1, 1, 1, 0, 0, 1, 32'h410, 32'h10, 32'h0, 32'h414); cyc(0);
    idle_in(); cyc(0);
    // PC wrap: not-taken at 0xFFFFFFFC, correct then mispredicted.
    drive(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h0); cyc(1);
    drive(1, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h8, 32'h0, 32'h10); cyc(1);
    idle_in(); cyc(0);
    // Saturation of both counters.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 1, 0, 0, 1, 32'h800 + 32'(i * 16), 32'h100, 32'h0, 32'h0); cyc(1);
      idle_in(); cyc(0);
    end
    // Reset during SQUASH, then immediate resolve works.
    drive(1, 0, 1, 0, 0, 1, 32'h900, 32'h20, 32'h0, 32'h904); cyc(1);
    cyc_reset();
    drive(1, 0, 1, 0, 0, 1, 32'h910, 32'h20, 32'h0, 32'h930); cyc(1);
    // Reset during HOLD: no late update, back to IDLE.
    drive(1, 1, 1, 0, 0, 1, 32'hA00, 32'h20, 32'h0, 32'hA04); cyc(1);
    drive(1, 1, 1, 0, 0, 1, 32'hA00, 32'h20, 32'h0, 32'hA04); cyc(0);
    cyc_reset();
    idle_in(); cyc(0);
    drive(1, 0, 1, 0, 0, 0, 32'hB00, 32'h20, 32'h0, 32'hB04); cyc(1);
    idle_in(); cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
